// File: rtl/uart_rx_byte.sv
// uart_rx_byte
//   8N1 UART receiver, LSB first. Bit timing comes from a clock-cycle counter
//   (CLKS_PER_BIT clocks per serial bit). The start bit is re-checked at its
//   midpoint, so glitches are rejected there. Every later sample is then taken
//   one bit period after the previous one, which keeps it mid-bit.
//
// Ports
//   clk        system clock, rising edge
//   nRst       synchronous active-low reset
//   rx_serial  asynchronous serial line, idles high
//   Rx_byte    last correctly framed byte (held between ready strobes)
//   ready      1-cycle strobe: Rx_byte updated this cycle
//   frame_err  1-cycle strobe: stop bit sampled low (Rx_byte untouched)
//   busy       high whenever the receiver is not idle
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 1042
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       rx_serial,
  output logic [7:0] Rx_byte,
  output logic       ready,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam logic [CW-1:0] HALF_C = CW'(HALF);
  localparam logic [CW-1:0] LAST_C = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [2:0]    bit_q,   bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    byte_q,  byte_d;
  logic          ready_q, ready_d;
  logic          ferr_q,  ferr_d;
  logic          busy_q,  busy_d;
  logic          sync1_q, sync1_d;
  logic          rx_s_q,  rx_s_d;

  always_comb begin
    sync1_d = rx_serial;
    rx_s_d  = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    ready_d = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_C) begin
          cnt_d = '0;
          // Still low at mid-start: a real start bit. Otherwise it was a glitch.
          if (!rx_s_q) begin
            state_d = DATA;
            bit_d   = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == LAST_C) begin
          cnt_d = '0;
          // The first bit received shifts down to bit 0 after eight samples.
          shift_d = {rx_s_q, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == LAST_C) begin
          cnt_d = '0;
          // Leave at mid-stop-bit so a back-to-back start edge lands in IDLE.
          if (rx_s_q) begin
            byte_d  = shift_q;
            ready_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_HIGH: begin
        // A break (line held low) must not be taken for a string of frames.
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      ready_q <= ready_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
      sync1_q <= sync1_d;
      rx_s_q  <= rx_s_d;
    end
  end

  assign Rx_byte   = byte_q;
  assign ready     = ready_q;
  assign frame_err = ferr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte at CLKS_PER_BIT=16. Every frame that is sent pushes its
// expected outcome (byte or framing error, plus the cycle of the strobe) onto a
// scoreboard. A negedge monitor pops one entry for each ready/frame_err pulse.
module tb_uart_rx_byte;
  localparam int CPB  = 16;
  localparam int HALF = (CPB - 1) / 2;
  // Cycles from the edge where the start bit is driven to the strobe cycle:
  // 2 synchronizer flops + IDLE detect (t0), then 1 + HALF + 9 bit periods.
  localparam int LAT  = 3 + 1 + HALF + 9 * CPB;

  logic       clk = 1'b0;
  logic       nRst = 1'b0;
  logic       rx_serial = 1'b1;
  logic [7:0] Rx_byte;
  logic       ready, frame_err, busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .nRst(nRst), .rx_serial(rx_serial),
    .Rx_byte(Rx_byte), .ready(ready), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor
  always @(negedge clk) begin
    if (ready === 1'b1 || frame_err === 1'b1) begin
      exp_t e;
      tests++;
      if (ready === 1'b1 && frame_err === 1'b1) begin
        fails++;
        $display("FAIL strobe_overlap: ready=%b frame_err=%b, required not both", ready, frame_err);
      end else if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_strobe: ready=%b frame_err=%b at cyc %0d, required none", ready, frame_err, cyc);
      end else begin
        e = sb.pop_front();
        if (frame_err !== e.err) begin
          fails++;
          $display("FAIL strobe_kind: frame_err=%b ready=%b, required frame_err=%b", frame_err, ready, e.err);
        end
        tests++;
        if (cyc !== e.cyc) begin
          fails++;
          $display("FAIL strobe_time: cyc %0d, required %0d", cyc, e.cyc);
        end
        if (!e.err) begin
          tests++;
          if (Rx_byte !== e.data) begin
            fails++;
            $display("FAIL rx_data: Rx_byte=%h, required %h", Rx_byte, e.data);
          end
        end
      end
    end
  end

  task automatic drive_for(input logic v, input int n);
    rx_serial = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Caller must be at posedge+#1. stop_hi=0 keeps the line low for the stop
  // bit plus extra_low cycles.
  task automatic send_byte(input logic [7:0] d, input bit stop_hi, input int extra_low);
    exp_t e;
    e.err  = !stop_hi;
    e.data = d;
    e.cyc  = cyc + LAT;
    sb.push_back(e);
    drive_for(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_for(d[i], CPB);
    if (stop_hi) drive_for(1'b1, CPB);
    else         drive_for(1'b0, CPB + extra_low);
  endtask

  task automatic check_drained(input string name);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: %0d strobes outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset;
    nRst = 1'b0;
    rx_serial = 1'b1;
    repeat (2) @(posedge clk);
    #1 nRst = 1'b1;
    @(negedge clk);
    tests++;
    if ({Rx_byte, ready, frame_err, busy} !== 11'h000) begin
      fails++;
      $display("FAIL reset_state: Rx_byte=%h ready=%b frame_err=%b busy=%b, required 00 0 0 0",
               Rx_byte, ready, frame_err, busy);
    end
    @(posedge clk); #1;
    drive_for(1'b1, 4);
  endtask

  task automatic test_single;
    int e0;
    int bad;
    e0 = cyc;
    bad = 0;
    fork
      send_byte(8'hA5, 1'b1, 0);
      begin
        // busy must rise one edge after t0 and fall with the ready strobe.
        for (int k = 0; k < LAT + 3; k++) begin
          @(negedge clk);
          tests++;
          if (busy !== ((cyc >= e0 + 3) && (cyc < e0 + LAT))) begin
            fails++;
            if (bad == 0)
              $display("FAIL busy_a5: busy=%b at offset %0d, required %b",
                       busy, cyc - e0, (cyc >= e0 + 3) && (cyc < e0 + LAT));
            bad++;
          end
        end
      end
    join
    check_drained("single");
  endtask

  task automatic test_back_to_back;
    send_byte(8'h00, 1'b1, 0);
    send_byte(8'hFF, 1'b1, 0);
    drive_for(1'b1, 4);
    check_drained("b2b");
  endtask

  task automatic test_glitch;
    int e0;
    logic [7:0] prev;
    prev = Rx_byte;
    e0 = cyc;
    drive_for(1'b0, 4);
    rx_serial = 1'b1;
    while (cyc < e0 + 3 + 1 + HALF - 1) @(negedge clk);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL glitch_busy_hi: busy=%b before start check, required 1", busy);
    end
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL glitch_busy_lo: busy=%b after start check, required 0", busy);
    end
    @(posedge clk); #1;
    drive_for(1'b1, 2 * CPB);
    tests++;
    if (Rx_byte !== prev) begin
      fails++;
      $display("FAIL glitch_byte: Rx_byte=%h, required %h", Rx_byte, prev);
    end
    check_drained("glitch");
  endtask

  task automatic test_framing;
    logic [7:0] prev;
    prev = Rx_byte;
    send_byte(8'h3C, 1'b0, 40);
    @(negedge clk);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL ferr_busy: busy=%b while line held low, required 1", busy);
    end
    tests++;
    if (Rx_byte !== prev) begin
      fails++;
      $display("FAIL ferr_byte: Rx_byte=%h, required %h", Rx_byte, prev);
    end
    @(posedge clk); #1;
    drive_for(1'b1, 6);
    send_byte(8'h5A, 1'b1, 0);
    drive_for(1'b1, 4);
    check_drained("framing");
  endtask

  task automatic test_reset_mid;
    logic [7:0] d;
    d = 8'h81;
    drive_for(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_for(d[i], CPB);
    drive_for(d[4], CPB / 2);
    // The host restarts along with the receiver, so the rest of the frame is
    // not sent; the line returns to idle.
    nRst = 1'b0;
    rx_serial = 1'b1;
    @(posedge clk); #1;
    nRst = 1'b1;
    drive_for(1'b1, 12 * CPB);
    @(negedge clk);
    tests++;
    if (Rx_byte !== 8'h00 || busy !== 1'b0) begin
      fails++;
      $display("FAIL midreset_state: Rx_byte=%h busy=%b, required 00 0", Rx_byte, busy);
    end
    @(posedge clk); #1;
    send_byte(8'h42, 1'b1, 0);
    drive_for(1'b1, 4);
    check_drained("midreset");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit, required completion");
    $fatal(1);
  end
endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- UART receiver directly upstream of the guess buffer; converts the serial line from the host into bytes.
- Produces Rx_byte plus a one-cycle ready strobe, which feed the buffer's Rx_byte/ready inputs.
- Fixed frame: 8N1, LSB first, oversampled by a clock-cycle counter; includes an input synchronizer, start-glitch rejection and framing-error detection.

Parameters:
- CLKS_PER_BIT, 1042, clk cycles per serial bit (10 MHz / 9600 baud); legal range >= 4.

Ports:
- clk  input  1  system clock, rising edge
- nRst  input  1  reset, synchronous, active-low
- rx_serial  input  1  asynchronous serial line, idles high
- Rx_byte  output  8  last correctly framed byte
- ready  output  1  one-cycle strobe: Rx_byte updated this cycle
- frame_err  output  1  one-cycle strobe: stop bit sampled low
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (nRst low at posedge clk): state=IDLE, counter=0, bit index=0, shift reg=0, both sync flops=1, Rx_byte=8'h00, ready=0, frame_err=0, busy=0. Applies mid-frame too: partial byte discarded, no strobe emitted.
- Synchronizer: rx_serial passes through 2 flops; all decisions below use the second flop (rx_s).
- Counter semantics: in START/DATA/STOP the counter increments each cycle. On reaching its terminal value, the state acts, the counter clears, and the state may advance.
- HALF = (CLKS_PER_BIT-1)/2, integer division.
- IDLE: rx_s==0 -> START, counter=0.
- START: terminal HALF. If rx_s==0, go to DATA with bit index 0. If rx_s==1, treat as a glitch: return to IDLE, no strobe.
- DATA: terminal CLKS_PER_BIT-1. Sample rx_s into the shift reg, shifting right with the sample inserted at bit 7, so the first received bit ends in bit 0. After bit index 7 is sampled, go to STOP; otherwise increment the bit index.
- STOP: terminal CLKS_PER_BIT-1.
  - rx_s==1: Rx_byte<=shift reg, ready<=1, go to IDLE.
  - rx_s==0: frame_err<=1, Rx_byte unchanged, go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s==1, then IDLE. Prevents a break (line held low) from retriggering frames.
- Timing: let t0 be the cycle IDLE sees rx_s==0.
  - Start bit is checked at t0+1+HALF.
  - Data bit k (0..7) is sampled at t0+1+HALF+(k+1)*CLKS_PER_BIT.
  - Stop bit is sampled at t0+1+HALF+9*CLKS_PER_BIT; ready/frame_err are high in the next cycle only.
- ready and frame_err are never high together; each is high for exactly 1 cycle per frame.
- Rx_byte is stable between ready strobes.
- Back-to-back frames: a start edge immediately after the stop bit is accepted. STOP exits at mid-stop-bit, so the next falling edge is seen in IDLE.
- busy = (state != IDLE), registered with the state.

Test Plan (CLKS_PER_BIT=16, ideal bit timing, line idle high):
- Reset: hold nRst low 2 cycles with rx_serial=1 -> Rx_byte=00, ready=0, frame_err=0, busy=0.
- Send 0xA5 -> exactly one ready pulse ~9.5 bit times after the start edge; Rx_byte=A5; busy high from the cycle after t0 until the pulse.
- Send 0x00 then 0xFF back-to-back with no idle gap -> two ready pulses, Rx_byte=00 then FF, no frame_err.
- Drive rx_serial low for 4 cycles, then high -> no ready or frame_err; busy drops back to 0 at the START check; Rx_byte unchanged.
- Send 0x3C with the stop bit forced low and the line held low 40 more cycles -> one frame_err pulse, no ready, Rx_byte keeps its prior value, busy stays high. Then release the line high and send 0x5A -> ready with Rx_byte=5A.
- Pulse nRst low for 1 cycle during data bit 4 of 0x81 -> no ready for that frame; Rx_byte=00. A following 0x42 is received correctly.
